// File: rtl/pixel_transformer_pipe_if.sv
// Pixel, configuration and result signals of pixel_transformer_pipe.
// The master drives pixels and configuration; the slave (the pipeline) drives the results.
interface pixel_transformer_pipe_if #(
  parameter int HWIDTH = 12,
  parameter int VWIDTH = 12,
  parameter int AWIDTH = 15,
  parameter int NLAYER = 4
);
  localparam int LW = (NLAYER > 1) ? $clog2(NLAYER) : 1;

  logic                     in_valid;
  logic [HWIDTH-1:0]        hdata;
  logic [VWIDTH-1:0]        vdata;
  logic                     frame_start;
  logic                     cfg_we;
  logic [LW-1:0]            cfg_layer;
  logic [HWIDTH-1:0]        cfg_hoffset;
  logic [VWIDTH-1:0]        cfg_voffset;
  logic                     cfg_enable;
  logic                     out_valid;
  logic [NLAYER*AWIDTH-1:0] out_addr;
  logic [NLAYER-1:0]        out_hit;
  logic                     out_any;
  logic [LW-1:0]            out_sel;
  logic                     cfg_pending;

  modport master (
    output in_valid, hdata, vdata, frame_start,
    output cfg_we, cfg_layer, cfg_hoffset, cfg_voffset, cfg_enable,
    input  out_valid, out_addr, out_hit, out_any, out_sel, cfg_pending
  );

  modport slave (
    input  in_valid, hdata, vdata, frame_start,
    input  cfg_we, cfg_layer, cfg_hoffset, cfg_voffset, cfg_enable,
    output out_valid, out_addr, out_hit, out_any, out_sel, cfg_pending
  );
endinterface

// File: rtl/pixel_transformer_pipe.sv
// Multi-layer pixel coordinate transformer: per-layer offset, downscale, bounds test and
// linear address generation in a fixed 3-stage pipeline with frame-synchronous config commit.
module pixel_transformer_pipe #(
  parameter int IWIDTH = 2,
  parameter int HWIDTH = 12,
  parameter int HSIZE  = 640,
  parameter int VWIDTH = 12,
  parameter int VSIZE  = 480,
  parameter int AWIDTH = 15,
  parameter int NLAYER = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pixel_transformer_pipe_if.slave  bus
);
  localparam int          LW   = (NLAYER > 1) ? $clog2(NLAYER) : 1;
  localparam int          HA_W = HWIDTH - IWIDTH;
  localparam int          VA_W = VWIDTH - IWIDTH;
  localparam int unsigned NL   = NLAYER;
  localparam int unsigned HDIV = HSIZE >> IWIDTH;
  localparam int unsigned VDIV = VSIZE >> IWIDTH;

  logic [HWIDTH-1:0] sh_hoff  [NLAYER];
  logic [VWIDTH-1:0] sh_voff  [NLAYER];
  logic [NLAYER-1:0] sh_en;
  logic [HWIDTH-1:0] act_hoff [NLAYER];
  logic [VWIDTH-1:0] act_voff [NLAYER];
  logic [NLAYER-1:0] act_en;
  logic [NLAYER-1:0] layer_wr;

  logic              s1_valid;
  logic [NLAYER-1:0] s1_en;
  logic [HWIDTH-1:0] s1_hs [NLAYER];
  logic [VWIDTH-1:0] s1_vs [NLAYER];

  logic [HA_W-1:0]   ha_c [NLAYER];
  logic [VA_W-1:0]   va_c [NLAYER];
  logic [NLAYER-1:0] hit_c;

  logic              s2_valid;
  logic [HA_W-1:0]   s2_ha [NLAYER];
  logic [VA_W-1:0]   s2_va [NLAYER];
  logic [NLAYER-1:0] s2_hit;

  logic [NLAYER*AWIDTH-1:0] addr_c;
  logic [LW-1:0]            sel_c;
  logic                     sel_found;

  // Out-of-range layer indices match no bit, so such writes are dropped.
  always_comb begin
    layer_wr = '0;
    for (int unsigned i = 0; i < NL; i++)
      layer_wr[i] = bus.cfg_we && (32'(bus.cfg_layer) == i);
  end

  // A write coinciding with frame_start goes straight into the active copy as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NL; i++) begin
        sh_hoff[i]  <= '0;
        sh_voff[i]  <= '0;
        act_hoff[i] <= '0;
        act_voff[i] <= '0;
      end
      sh_en  <= '0;
      act_en <= '0;
    end else begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (layer_wr[i]) begin
          sh_hoff[i] <= bus.cfg_hoffset;
          sh_voff[i] <= bus.cfg_voffset;
          sh_en[i]   <= bus.cfg_enable;
        end
        if (bus.frame_start) begin
          act_hoff[i] <= layer_wr[i] ? bus.cfg_hoffset : sh_hoff[i];
          act_voff[i] <= layer_wr[i] ? bus.cfg_voffset : sh_voff[i];
          act_en[i]   <= layer_wr[i] ? bus.cfg_enable  : sh_en[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.cfg_pending <= 1'b0;
    else if (bus.frame_start)
      bus.cfg_pending <= 1'b0;
    else if (bus.cfg_we)
      bus.cfg_pending <= 1'b1;
  end

  // Stage 1: offset add, wrapping modulo the coordinate width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_en    <= '0;
      for (int unsigned i = 0; i < NL; i++) begin
        s1_hs[i] <= '0;
        s1_vs[i] <= '0;
      end
    end else begin
      s1_valid <= bus.in_valid;
      s1_en    <= act_en;
      for (int unsigned i = 0; i < NL; i++) begin
        s1_hs[i] <= bus.hdata + act_hoff[i];
        s1_vs[i] <= bus.vdata + act_voff[i];
      end
    end
  end

  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      ha_c[i]  = s1_hs[i][HWIDTH-1:IWIDTH];
      va_c[i]  = s1_vs[i][VWIDTH-1:IWIDTH];
      hit_c[i] = s1_valid && s1_en[i] && (32'(ha_c[i]) < HDIV) && (32'(va_c[i]) < VDIV);
    end
  end

  // Stage 2: downscale and bounds test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_hit   <= '0;
      for (int unsigned i = 0; i < NL; i++) begin
        s2_ha[i] <= '0;
        s2_va[i] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      s2_hit   <= hit_c;
      for (int unsigned i = 0; i < NL; i++) begin
        s2_ha[i] <= ha_c[i];
        s2_va[i] <= va_c[i];
      end
    end
  end

  always_comb begin
    addr_c    = '0;
    sel_c     = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NL; i++) begin
      if (s2_hit[i])
        addr_c[i*AWIDTH +: AWIDTH] = AWIDTH'(32'(s2_va[i]) * HDIV + 32'(s2_ha[i]));
      if (s2_hit[i] && !sel_found) begin
        sel_c     = LW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Stage 3: address, hit summary and priority select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_hit   <= '0;
      bus.out_any   <= 1'b0;
      bus.out_sel   <= '0;
    end else begin
      bus.out_valid <= s2_valid;
      bus.out_addr  <= addr_c;
      bus.out_hit   <= s2_hit;
      bus.out_any   <= |s2_hit;
      bus.out_sel   <= sel_c;
    end
  end
endmodule

// File: tb/tb_pixel_transformer_pipe.sv
// Bench for pixel_transformer_pipe: directed scenarios plus randomized traffic
// checked each cycle against an arithmetic reference model of the transform.
module tb_pixel_transformer_pipe;
  localparam int IWIDTH = 2;
  localparam int HWIDTH = 12;
  localparam int HSIZE  = 640;
  localparam int VWIDTH = 12;
  localparam int VSIZE  = 480;
  localparam int AWIDTH = 15;
  localparam int NLAYER = 4;
  localparam int LW     = 2;
  localparam int SCALE  = 1 << IWIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pixel_transformer_pipe_if #(
    .HWIDTH(HWIDTH), .VWIDTH(VWIDTH), .AWIDTH(AWIDTH), .NLAYER(NLAYER)
  ) bus ();

  pixel_transformer_pipe #(
    .IWIDTH(IWIDTH), .HWIDTH(HWIDTH), .HSIZE(HSIZE), .VWIDTH(VWIDTH),
    .VSIZE(VSIZE), .AWIDTH(AWIDTH), .NLAYER(NLAYER)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic                     valid;
    logic [NLAYER*AWIDTH-1:0] addr;
    logic [NLAYER-1:0]        hit;
    logic                     any;
    logic [LW-1:0]            sel;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  int sh_h[NLAYER], sh_v[NLAYER], ac_h[NLAYER], ac_v[NLAYER];
  bit sh_en[NLAYER], ac_en[NLAYER];
  bit pend;
  exp_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NLAYER; i++) begin
      sh_h[i] = 0; sh_v[i] = 0; sh_en[i] = 0;
      ac_h[i] = 0; ac_v[i] = 0; ac_en[i] = 0;
    end
    pend = 0;
    q.delete();
    q.push_back('0);
    q.push_back('0);
  endfunction

  function automatic exp_t predict(bit valid, int h, int v);
    exp_t e;
    int hs, vs, ha, va;
    e = '0;
    e.valid = valid;
    for (int i = 0; i < NLAYER; i++) begin
      hs = (h + ac_h[i]) % (1 << HWIDTH);
      vs = (v + ac_v[i]) % (1 << VWIDTH);
      ha = hs / SCALE;
      va = vs / SCALE;
      if (valid && ac_en[i] && ha < HSIZE / SCALE && va < VSIZE / SCALE) begin
        e.hit[i] = 1'b1;
        e.addr[i*AWIDTH +: AWIDTH] = AWIDTH'((va * (HSIZE / SCALE) + ha) % (1 << AWIDTH));
      end
    end
    e.any = |e.hit;
    for (int i = NLAYER - 1; i >= 0; i--)
      if (e.hit[i]) e.sel = LW'(i);
    return e;
  endfunction

  task automatic check_zero();
    check("rst_valid",   64'(bus.out_valid),   64'(0));
    check("rst_addr",    64'(bus.out_addr),    64'(0));
    check("rst_hit",     64'(bus.out_hit),     64'(0));
    check("rst_any",     64'(bus.out_any),     64'(0));
    check("rst_sel",     64'(bus.out_sel),     64'(0));
    check("rst_pending", 64'(bus.cfg_pending), 64'(0));
  endtask

  // One clock: snapshot inputs, let the edge pass, then compare against the model.
  task automatic tick();
    exp_t e;
    bit we, fs, en;
    int lay, ho, vo;
    e   = predict(bus.in_valid, int'(bus.hdata), int'(bus.vdata));
    we  = bus.cfg_we;
    fs  = bus.frame_start;
    en  = bus.cfg_enable;
    lay = int'(bus.cfg_layer);
    ho  = int'(bus.cfg_hoffset);
    vo  = int'(bus.cfg_voffset);
    @(posedge clk);
    if (rst_n) begin
      if (we && lay < NLAYER) begin
        sh_h[lay] = ho; sh_v[lay] = vo; sh_en[lay] = en;
      end
      if (fs) begin
        ac_h = sh_h; ac_v = sh_v; ac_en = sh_en;
      end
      if (fs) pend = 0;
      else if (we) pend = 1;
      q.push_back(e);
    end
    #1;
    if (!rst_n) begin
      check_zero();
    end else begin
      e = q.pop_front();
      check("valid",   64'(bus.out_valid),   64'(e.valid));
      check("addr",    64'(bus.out_addr),    64'(e.addr));
      check("hit",     64'(bus.out_hit),     64'(e.hit));
      check("any",     64'(bus.out_any),     64'(e.any));
      check("sel",     64'(bus.out_sel),     64'(e.sel));
      check("pending", 64'(bus.cfg_pending), 64'(pend));
    end
  endtask

  task automatic send(input int h, input int v);
    bus.in_valid = 1'b1;
    bus.hdata    = HWIDTH'(h);
    bus.vdata    = VWIDTH'(v);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic configure(input int lay, input int ho, input int vo, input bit en, input bit fs);
    bus.cfg_we      = 1'b1;
    bus.cfg_layer   = LW'(lay);
    bus.cfg_hoffset = HWIDTH'(ho);
    bus.cfg_voffset = VWIDTH'(vo);
    bus.cfg_enable  = en;
    bus.frame_start = fs;
    tick();
    bus.cfg_we      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.hdata = '0; bus.vdata = '0; bus.frame_start = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_layer = '0; bus.cfg_hoffset = '0; bus.cfg_voffset = '0;
    bus.cfg_enable = 1'b0;
    do_reset();

    // Basic hit on layer 0.
    configure(0, 0, 0, 1'b1, 1'b1);
    send(8, 4);
    idle(2);
    check("d38_valid", 64'(bus.out_valid), 64'(1));
    check("d38_hit0",  64'(bus.out_hit[0]), 64'(1));
    check("d38_addr0", 64'(bus.out_addr[0 +: AWIDTH]), 64'(162));
    check("d38_sel",   64'(bus.out_sel), 64'(0));

    // Negative sum wraps to a miss.
    configure(0, -8, 0, 1'b1, 1'b1);
    send(4, 0);
    idle(2);
    check("d39_hit0",  64'(bus.out_hit[0]), 64'(0));
    check("d39_addr0", 64'(bus.out_addr[0 +: AWIDTH]), 64'(0));
    check("d39_any",   64'(bus.out_any), 64'(0));

    // Right/bottom edge and one past it.
    configure(0, 0, 0, 1'b1, 1'b1);
    send(639, 479);
    send(640, 479);
    idle(1);
    check("d40_addr0", 64'(bus.out_addr[0 +: AWIDTH]), 64'(19199));
    check("d40_hit0",  64'(bus.out_hit[0]), 64'(1));
    idle(1);
    check("d40_miss0", 64'(bus.out_hit[0]), 64'(0));

    // Priority select with only layer 2 enabled.
    configure(0, 0, 0, 1'b0, 1'b0);
    configure(2, 4, 0, 1'b1, 1'b1);
    send(0, 0);
    idle(2);
    check("d41_hit",   64'(bus.out_hit), 64'(4'b0100));
    check("d41_sel",   64'(bus.out_sel), 64'(2));
    check("d41_addr2", 64'(bus.out_addr[2*AWIDTH +: AWIDTH]), 64'(1));

    // Shadow write stays pending; write with frame_start commits for the next pixel.
    configure(2, 8, 0, 1'b1, 1'b0);
    check("d42_pend1", 64'(bus.cfg_pending), 64'(1));
    send(0, 0);
    idle(2);
    check("d42_old",   64'(bus.out_addr[2*AWIDTH +: AWIDTH]), 64'(1));
    bus.in_valid = 1'b1; bus.hdata = '0; bus.vdata = '0;
    configure(2, 12, 0, 1'b1, 1'b1);
    check("d42_pend0", 64'(bus.cfg_pending), 64'(0));
    send(0, 0);
    idle(1);
    check("d42_same",  64'(bus.out_addr[2*AWIDTH +: AWIDTH]), 64'(1));
    idle(1);
    check("d42_new",   64'(bus.out_addr[2*AWIDTH +: AWIDTH]), 64'(3));

    // Reset pulse in the middle of a five-pixel stream.
    send(16, 16);
    send(20, 16);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero();
    send(24, 16);
    rst_n = 1'b1;
    send(28, 16);
    check("d43_v0", 64'(bus.out_valid), 64'(0));
    send(32, 16);
    check("d43_v1", 64'(bus.out_valid), 64'(0));
    idle(1);
    check("d43_v2", 64'(bus.out_valid), 64'(1));
    idle(2);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.hdata    = HWIDTH'($urandom_range(0, 700));
      bus.vdata    = VWIDTH'($urandom_range(0, 530));
      bus.cfg_we   = 1'($urandom_range(0, 7) == 0);
      bus.cfg_layer = LW'($urandom_range(0, NLAYER - 1));
      if ($urandom_range(0, 3) == 0) begin
        bus.cfg_hoffset = HWIDTH'($urandom);
        bus.cfg_voffset = VWIDTH'($urandom);
      end else begin
        bus.cfg_hoffset = HWIDTH'($urandom_range(0, 80) - 40);
        bus.cfg_voffset = VWIDTH'($urandom_range(0, 80) - 40);
      end
      bus.cfg_enable  = 1'($urandom_range(0, 3) != 0);
      bus.frame_start = 1'($urandom_range(0, 15) == 0);
      tick();
    end
    bus.cfg_we = 1'b0;
    bus.frame_start = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_transformer_pipe.md
PIXEL_TRANSFORMER_PIPE -- requirements
Module: pixel_transformer_pipe

Interface
REQ-001 SHALL have parameter IWIDTH, default 2: log2 of the integer downscale factor applied to both axes.
REQ-002 SHALL have parameter HWIDTH, default 12: horizontal coordinate and offset width.
REQ-003 SHALL have parameter HSIZE, default 640: horizontal extent in pixels, before downscale.
REQ-004 SHALL have parameter VWIDTH, default 12: vertical coordinate and offset width.
REQ-005 SHALL have parameter VSIZE, default 480: vertical extent in pixels, before downscale.
REQ-006 SHALL have parameter AWIDTH, default 15: per-layer address width.
REQ-007 SHALL have parameter NLAYER, default 4: number of independent offset layers; LW = max(1, clog2(NLAYER)).
REQ-008 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-009 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-010 SHALL have in_valid, input, 1: pixel coordinate valid this cycle.
REQ-011 SHALL have hdata, input, HWIDTH: unsigned horizontal pixel coordinate.
REQ-012 SHALL have vdata, input, VWIDTH: unsigned vertical pixel coordinate.
REQ-013 SHALL have frame_start, input, 1: one-cycle frame boundary pulse.
REQ-014 SHALL have cfg_we, input, 1: write strobe for the shadow configuration.
REQ-015 SHALL have cfg_layer, input, LW: index of the layer being written.
REQ-016 SHALL have cfg_hoffset, input, HWIDTH: signed horizontal offset.
REQ-017 SHALL have cfg_voffset, input, VWIDTH: signed vertical offset.
REQ-018 SHALL have cfg_enable, input, 1: layer enable.
REQ-019 SHALL have out_valid, output, 1: delayed copy of in_valid.
REQ-020 SHALL have out_addr, output, NLAYER*AWIDTH: per-layer address; layer i occupies bits [i*AWIDTH +: AWIDTH].
REQ-021 SHALL have out_hit, output, NLAYER: per-layer in-bounds flag.
REQ-022 SHALL have out_any, output, 1: OR of out_hit.
REQ-023 SHALL have out_sel, output, LW: lowest-index layer that is hit.
REQ-024 SHALL have cfg_pending, output, 1: shadow configuration written but not yet committed.

Function
REQ-025 Each layer SHALL hold shadow and active copies of {hoffset, voffset, enable}; cfg_we writes the shadow copy of layer cfg_layer; cfg_layer >= NLAYER is ignored.
REQ-026 On frame_start, every layer's active copy SHALL load its shadow copy; a cfg_we in the same cycle is included in the commit (write-through).
REQ-027 cfg_pending SHALL set on cfg_we without frame_start and clear on frame_start; when both occur in one cycle it reads 0 next cycle.
REQ-028 Pixel path SHALL be a fixed 3-stage pipeline with no backpressure, latency 3 cycles, throughput 1 pixel per clock.
REQ-029 Stage 1 SHALL register hs_i = (hdata + hoffset_i) mod 2^HWIDTH and vs_i = (vdata + voffset_i) mod 2^VWIDTH, using the active offsets in effect in the input cycle.
REQ-030 Stage 2 SHALL register ha_i = hs_i[HWIDTH-1:IWIDTH], va_i = vs_i[VWIDTH-1:IWIDTH], and hit_i = in_valid & enable_i & (ha_i < HSIZE>>IWIDTH) & (va_i < VSIZE>>IWIDTH).
REQ-031 Negative sums SHALL wrap to large unsigned values and therefore be reported as miss, never clamped.
REQ-032 Stage 3 SHALL register addr_i = (va_i*(HSIZE>>IWIDTH) + ha_i) truncated to AWIDTH when hit_i = 1; otherwise addr_i = 0.
REQ-033 out_any and out_sel SHALL be registered in stage 3 from the stage-2 hits; out_sel = 0 when no layer is hit.
REQ-034 When in_valid = 0, the pipeline SHALL still advance; out_valid = 0 and all hits = 0 for that slot.
REQ-035 A frame_start commit SHALL affect only pixels presented on or after the cycle following frame_start.

Reset
REQ-036 While rst_n = 0, all pipeline registers, outputs, cfg_pending, and shadow and active configuration SHALL be 0 (offsets 0, layers disabled).
REQ-037 Reset asserted mid-stream SHALL discard in-flight pixels; the first valid output after release appears 3 cycles after the first in_valid.

Verification
REQ-038 Layer 0 configured with offsets 0, enabled, committed; h = 8, v = 4 -> 3 cycles later out_valid = 1, out_hit[0] = 1, addr0 = 162, out_sel = 0.
REQ-039 Layer 0 hoffset = -8; h = 4, v = 0 -> hs = 0xFFC, ha = 1023, out_hit[0] = 0, addr0 = 0, out_any = 0.
REQ-040 Boundary: offsets 0, h = 639, v = 479 -> addr0 = 19199, hit = 1; h = 640 -> hit = 0.
REQ-041 Layer 0 disabled, layer 2 enabled with hoffset = 4; h = 0, v = 0 -> out_hit = 0100, out_sel = 2, addr2 = 1.
REQ-042 cfg_we without frame_start -> cfg_pending = 1 and outputs still use the old offsets; cfg_we together with frame_start -> cfg_pending = 0 and the new offset is used from the next pixel.
REQ-043 Assert rst_n = 0 for 1 cycle during a stream of 5 valid pixels -> all outputs 0, and out_valid stays 0 until 3 cycles after the next in_valid.
